imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program-memory writer: fills instruction memory from a byte stream before and between runs.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Drives the program-memory write port and holds the processor core (cpu_hold) for the whole load.
- Sits beside the fetch stage; it owns the write side of the memory that fetch only reads.

Parameters:
ADDR_W, 10, word-address width of program memory; DEPTH = 2**ADDR_W words
BASE_ADDR, 0, first word address written

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load (honoured only in IDLE, DONE or ERROR)
s_data  input  8  stream byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts byte this cycle
imem_we  output  1  program-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for write
imem_wdata  output  32  instruction word
cpu_hold  output  1  core held in reset/freeze while 1
done  output  1  level; load completed with good checksum
error  output  1  level; oversize count or checksum mismatch

Behaviour:
- Reset: state IDLE; s_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=0, done=0, error=0. Reset mid-load abandons the frame; words already written stay in memory.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (MSB first), then one CHK byte.
- CHK rule: the 8-bit sum of all frame bytes, including the LEN bytes and CHK, equals 0 mod 256.
- Byte transfer: occurs on s_valid && s_ready.
  - s_ready=1 only in states LEN_HI, LEN_LO, DATA, CHK.
  - s_ready does not depend combinationally on s_valid.
- State machine: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERROR.
  - IDLE/DONE/ERROR + start -> LEN_HI: cpu_hold=1, done=0, error=0, running sum=0, word counter=0, imem_addr=BASE_ADDR.
  - start is ignored in all other states.
  - LEN_HI -> LEN_LO on transfer.
  - LEN_LO -> on transfer: N>DEPTH-BASE_ADDR gives ERROR; N==0 gives CHK; otherwise DATA.
  - DATA: shift each byte into a 32-bit assembly register, with a 2-bit byte index.
  - On the 4th byte transfer, the next cycle has imem_we=1 with that word on imem_wdata and its address on imem_addr.
  - imem_addr increments the cycle after each write; the address sequence is BASE_ADDR, BASE_ADDR+1, ...
  - After the write of word N, the next state is CHK. Back-to-back bytes are supported at 1 byte/cycle without stalls.
  - CHK -> on transfer: sum==0 gives DONE (done=1, cpu_hold=0 the next cycle); otherwise ERROR.
  - ERROR: error=1, cpu_hold stays 1, s_ready=0.
- Width rules:
  - Sum is 8-bit wrap-around.
  - Word counter is 16-bit, compared to N.
  - imem_addr never exceeds BASE_ADDR+N-1, guaranteed by the LEN_LO range check.
- Simultaneous events: rst dominates start and any transfer. A start pulse coinciding with s_valid in IDLE does not consume the byte.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum loader_state_t.
  - frame constants LEN_BYTES=2, WORD_BYTES=4.
  - checksum width CHK_W=8.
- One sub-module, byte_to_word_packer: 8-to-32 big-endian assembler.
  - Inputs: byte, valid, clear.
  - Outputs: word, word_valid pulse.
  - Holds the byte index and assembly register.

Test Plan:
- Basic load: frame 00 02 | 11 22 33 44 | AA BB CC DD | CHK with BASE_ADDR=0, valid held high -> imem_we pulses carry addr 0 / data 0x11223344, then addr 1 / data 0xAABBCCDD; then done=1, cpu_hold=0, error=0.
- Backpressure and gaps: same frame with s_valid toggling randomly -> identical writes and identical final state; no byte lost or duplicated.
- Bad checksum: correct frame with CHK+1 -> both words are written, then error=1, done=0, cpu_hold stays 1; a new start clears error.
- Oversize count: N=0x0401 with ADDR_W=10 -> ERROR right after LEN_LO, no imem_we, s_ready=0.
- Zero-length and start handling: N=0 with CHK=0x00 -> DONE with no writes. A start pulse during DATA is ignored and the load completes normally.
- Reset mid-load: assert rst after 6 data bytes -> the next cycle has all outputs at reset values; word 0 remains written; a following full load overwrites from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the program-memory loader.
// Imported by the loader top and its byte packer.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHK,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CHK_W      = 8;

   function automatic logic is_rx_state(input loader_state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
             (s == ST_DATA)   || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Big-endian byte-to-word assembler; emits a registered one-cycle
// word_valid pulse carrying the word completed by the previous byte.
module byte_to_word_packer
   import imem_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              byte_i,
   input  logic                    valid_i,
   input  logic                    clear_i,
   output logic [WORD_BYTES*8-1:0] word_o,
   output logic                    word_valid_o,
   output logic                    last_byte_o
);

   localparam int IDX_W  = $clog2(WORD_BYTES);
   localparam int WORD_W = WORD_BYTES * 8;

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              wv_q, wv_d;

   // High when the next accepted byte completes a word.
   assign last_byte_o  = (idx_q == IDX_W'(WORD_BYTES - 1));
   assign word_o       = word_q;
   assign word_valid_o = wv_q;

   always_comb begin
      idx_d  = idx_q;
      asm_d  = asm_q;
      word_d = word_q;
      wv_d   = 1'b0;
      if (clear_i) begin
         idx_d = '0;
         asm_d = '0;
      end else if (valid_i) begin
         asm_d = {asm_q[WORD_W-9:0], byte_i};
         idx_d = idx_q + IDX_W'(1);
         if (last_byte_o) begin
            word_d = {asm_q[WORD_W-9:0], byte_i};
            wv_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         asm_q  <= '0;
         word_q <= '0;
         wv_q   <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         asm_q  <= asm_d;
         word_q <= word_d;
         wv_q   <= wv_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for program memory; holds the core while
// a load is in progress and reports checksum / length failures.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int          LEN_W   = LEN_BYTES * 8;
   localparam longint      DEPTH   = longint'(1) << ADDR_W;
   localparam logic [31:0] LEN_MAX = 32'(DEPTH - longint'(BASE_ADDR));

   loader_state_t      state_q, state_d;
   logic [CHK_W-1:0]   sum_q, sum_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [7:0]         len_hi_q, len_hi_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               ready_q, ready_d;
   logic               hold_q, hold_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               pk_clear;
   logic               pk_valid;
   logic               pk_last;
   logic               pk_wv;
   logic [31:0]        pk_word;
   logic [CHK_W-1:0]   sum_nxt;
   logic [LEN_W-1:0]   len_full;

   assign xfer     = s_valid && ready_q;
   assign sum_nxt  = sum_q + s_data;
   assign len_full = {len_hi_q, s_data};
   assign pk_valid = xfer && (state_q == ST_DATA);

   byte_to_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .byte_i       (s_data),
      .valid_i      (pk_valid),
      .clear_i      (pk_clear),
      .word_o       (pk_word),
      .word_valid_o (pk_wv),
      .last_byte_o  (pk_last)
   );

   assign s_ready    = ready_q;
   assign imem_we    = pk_wv;
   assign imem_wdata = pk_word;
   assign imem_addr  = addr_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = err_q;

   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      len_d    = len_q;
      len_hi_d = len_hi_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      hold_d   = hold_q;
      done_d   = done_q;
      err_d    = err_q;
      pk_clear = 1'b0;

      // The last word is written while already in CHK, so the address
      // stops at BASE_ADDR+N-1.
      if (pk_wv && state_q == ST_DATA)
         addr_d = addr_q + ADDR_W'(1);

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d  = ST_LEN_HI;
               hold_d   = 1'b1;
               done_d   = 1'b0;
               err_d    = 1'b0;
               sum_d    = '0;
               cnt_d    = '0;
               addr_d   = ADDR_W'(BASE_ADDR);
               pk_clear = 1'b1;
            end
         end
         ST_LEN_HI: begin
            if (xfer) begin
               len_hi_d = s_data;
               sum_d    = sum_nxt;
               state_d  = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (xfer) begin
               len_d = len_full;
               sum_d = sum_nxt;
               if (32'(len_full) > LEN_MAX) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (len_full == '0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               sum_d = sum_nxt;
               if (pk_last) begin
                  cnt_d = cnt_q + LEN_W'(1);
                  if (cnt_q + LEN_W'(1) == len_q)
                     state_d = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (xfer) begin
               sum_d = sum_nxt;
               if (sum_nxt == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = is_rx_state(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sum_q    <= '0;
         len_q    <= '0;
         len_hi_q <= '0;
         cnt_q    <= '0;
         addr_q   <= ADDR_W'(BASE_ADDR);
         ready_q  <= 1'b0;
         hold_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sum_q    <= sum_d;
         len_q    <= len_d;
         len_hi_q <= len_hi_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         ready_q  <= ready_d;
         hold_q   <= hold_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus a
// mid-load reset sequence, with a write scoreboard.
module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      int          len;
      logic [31:0] w0;
      logic [31:0] w1;
      int          delta;
      int          gap;
      int          start_at;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  frame_q[$];
   wr_t         sb_q[$];
   logic [31:0] tb_mem [0:DEPTH-1];
   vec_t        vecs [9];

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and score any write seen there.
   task automatic tick();
      wr_t e;
      @(negedge clk);
      if (imem_we === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     imem_addr, imem_wdata);
         end else begin
            e = sb_q.pop_front();
            if (imem_addr !== e.addr || imem_wdata !== e.data) begin
               bad++;
               $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                        imem_addr, imem_wdata, e.addr, e.data);
            end
         end
         tb_mem[imem_addr] = imem_wdata;
      end
   endtask

   task automatic build_frame(input vec_t v);
      logic [15:0] l;
      logic [7:0]  sum;
      logic [31:0] w;
      wr_t         e;
      frame_q.delete();
      l   = 16'(v.len);
      sum = l[15:8] + l[7:0];
      frame_q.push_back(l[15:8]);
      frame_q.push_back(l[7:0]);
      if (v.len > DEPTH) return;
      for (int i = 0; i < v.len; i++) begin
         w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : $urandom();
         for (int b = 3; b >= 0; b--) begin
            frame_q.push_back(w[b*8 +: 8]);
            sum = sum + w[b*8 +: 8];
         end
         e.addr = ADDR_W'(i);
         e.data = w;
         sb_q.push_back(e);
      end
      frame_q.push_back(8'(8'h00 - sum + 8'(v.delta)));
   endtask

   // Start pulse coincides with the first byte offered; IDLE must not take it.
   task automatic pulse_start();
      start   = 1'b1;
      s_valid = 1'b1;
      s_data  = frame_q[0];
      tick();
      start   = 1'b0;
      s_valid = 1'b0;
      check("start_error", {31'd0, error}, 32'd0);
      check("start_done", {31'd0, done}, 32'd0);
      check("start_hold", {31'd0, cpu_hold}, 32'd1);
      check("start_ready", {31'd0, s_ready}, 32'd1);
   endtask

   task automatic drive_frame(input int gap, input int start_at,
                              input int limit);
      int   idx = 0;
      int   cyc = 0;
      int   n;
      logic started = 1'b0;
      logic xf;
      n = (limit < 0) ? frame_q.size() : limit;
      while (idx < n && cyc < 20000) begin
         start = (idx == start_at) && !started;
         if (start) started = 1'b1;
         if (gap > 0 && $urandom_range(99) < gap) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = frame_q[idx];
         end
         xf = s_valid && s_ready;
         tick();
         if (xf) idx++;
         cyc++;
      end
      start   = 1'b0;
      s_valid = 1'b0;
      if (idx < n) begin
         total++;
         bad++;
         $display("FAIL drive_timeout: got %0d bytes expected %0d", idx, n);
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int lat = 0;
      build_frame(v);
      pulse_start();
      drive_frame(v.gap, v.start_at, -1);
      while (!(done || error) && lat < 50) begin
         tick();
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'd0);
      check({name, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
      check({name, "_error"}, {31'd0, error}, {31'd0, v.exp_err});
      check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, v.exp_err});
      check({name, "_ready"}, {31'd0, s_ready}, 32'd0);
      tick();
      tick();
      check({name, "_pending"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   initial begin
      vec_t vm;
      vecs[0] = '{2, 32'h11223344, 32'hAABBCCDD, 0, 0, -1, 1'b1, 1'b0};
      vecs[1] = '{2, 32'h11223344, 32'hAABBCCDD, 0, 45, -1, 1'b1, 1'b0};
      vecs[2] = '{2, 32'h11223344, 32'hAABBCCDD, 1, 0, -1, 1'b0, 1'b1};
      vecs[3] = '{3, 32'hDEADBEEF, 32'h00000001, 0, 0, -1, 1'b1, 1'b0};
      vecs[4] = '{16'h0401, 32'h0, 32'h0, 0, 0, -1, 1'b0, 1'b1};
      vecs[5] = '{0, 32'h0, 32'h0, 0, 0, -1, 1'b1, 1'b0};
      vecs[6] = '{3, 32'hCAFEF00D, 32'h12345678, 0, 0, 5, 1'b1, 1'b0};
      vecs[7] = '{8, 32'hFFFFFFFF, 32'h80000000, 0, 30, -1, 1'b1, 1'b0};
      vecs[8] = '{DEPTH, 32'h0BADC0DE, 32'h76543210, 0, 0, -1, 1'b1, 1'b0};

      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      repeat (3) tick();
      check("rst_ready", {31'd0, s_ready}, 32'd0);
      check("rst_we", {31'd0, imem_we}, 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_hold", {31'd0, cpu_hold}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++)
         run_vec($sformatf("vec%0d", i), vecs[i]);

      vm = '{2, 32'h01020304, 32'h05060708, 0, 0, -1, 1'b1, 1'b0};
      build_frame(vm);
      pulse_start();
      drive_frame(0, -1, 8);
      rst = 1'b1;
      tick();
      check("midrst_ready", {31'd0, s_ready}, 32'd0);
      check("midrst_we", {31'd0, imem_we}, 32'd0);
      check("midrst_addr", 32'(imem_addr), 32'd0);
      check("midrst_wdata", imem_wdata, 32'd0);
      check("midrst_hold", {31'd0, cpu_hold}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_error", {31'd0, error}, 32'd0);
      rst = 1'b0;
      tick();
      check("midrst_left", 32'(sb_q.size()), 32'd1);
      check("midrst_word0", tb_mem[0], 32'h01020304);
      sb_q.delete();

      vm = '{2, 32'h99887766, 32'h55443322, 0, 0, -1, 1'b1, 1'b0};
      run_vec("reload", vm);
      check("reload_word0", tb_mem[0], 32'h99887766);
      check("reload_word1", tb_mem[1], 32'h55443322);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
